mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single on-chip ram (one combinational read port, one synchronous write port, memory-mapped UART at IO space) between NUM_PORTS requesters.
- Port 0 is CPU instruction fetch, port 1 is CPU load/store, port 2 is the boot loader writing firmware.
- One memory transaction per clock, fair round-robin grant, request/grant handshake, registered read data.
- Sits between the core/loader and the ram instance in the top level.

Parameters:
- ADDRESS_WIDTH, 12, byte address width; matches ram.
- WIDTH, 32, data word width; matches ram.
- NUM_PORTS, 3, number of requesters (2..4 supported).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- port_req  input  NUM_PORTS  per-port request; held until granted
- port_we  input  NUM_PORTS  per-port write (1) / read (0)
- port_addr  input  NUM_PORTS*ADDRESS_WIDTH  packed byte addresses; port i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- port_wdata  input  NUM_PORTS*WIDTH  packed write data
- port_gnt  output  NUM_PORTS  one-hot, combinational; transaction accepted this cycle
- port_rvalid  output  NUM_PORTS  one-hot, registered; read data valid for that port
- port_rdata  output  WIDTH  shared read data, qualified by port_rvalid
- mem_we  output  1  to ram write_enable
- mem_raddr  output  ADDRESS_WIDTH  to ram read_addr
- mem_waddr  output  ADDRESS_WIDTH  to ram write_addr
- mem_wdata  output  WIDTH  to ram data_in
- mem_rdata  input  WIDTH  from ram data_out

Behaviour:
- Grant: port_gnt is the one-hot selection among the asserted port_req, searched starting at ptr and wrapping modulo NUM_PORTS. It is all-zero when no request is asserted.
- Pointer: on any grant to port i, ptr <= (i+1) mod NUM_PORTS. With no grant, ptr holds. Reset ptr = 0.
- Fairness: a continuously asserted request is granted within NUM_PORTS cycles.
- Memory drive, same cycle as grant:
  - mem_raddr = mem_waddr = granted port's address.
  - mem_wdata = granted port's data.
  - mem_we = gnt & port_we.
  - With no grant: mem_we = 0 and addresses/data = 0.
- Reads, 1-cycle latency:
  - On a read grant to port i, port_rdata <= mem_rdata and port_rvalid <= one-hot(i), both registered.
  - port_rvalid is a one-cycle pulse.
  - port_rdata holds its last value when rvalid = 0.
- Writes: complete in the grant cycle; no rvalid is produced.
- Back-to-back: the same port may be granted on consecutive cycles only if no other port requests. One transaction per cycle sustained; no bubbles.
- Requester rule: port_we, port_addr and port_wdata must be stable while port_req = 1 and port_gnt = 0. The requester deasserts port_req or presents a new request after port_gnt.
- UART region: no special casing. Reads and writes at IO addresses pass through; the UART status read returns the value sampled in the grant cycle.
- Read of an address written in the previous cycle returns the new data; the ram write is complete at that edge.
- Reset:
  - port_rvalid = 0, port_rdata = 0, ptr = 0.
  - port_gnt and mem_we are 0 during rst, even if requests are present.
  - A read granted in the cycle before rst asserts produces no rvalid while rst = 1.
- Illegal port_req with NUM_PORTS bits all zero: idle, no state change.

Decomposition:
- Shared header mem_defs.vh holds:
  - ADDRESS_WIDTH/WIDTH defaults.
  - Port index constants PORT_IFETCH = 0, PORT_LSU = 1, PORT_LOADER = 2.
  - UART_OFFSET/IO base constants, also used by ram.
- Sub-module rr_arbiter(clk, rst, req, gnt): purely the pointer plus rotating priority grant, parameterised by N.
- mem_arbiter instantiates rr_arbiter and adds the muxing and read-return register.

Test Plan:
- Single read: port1 reads addr 0x010 (mem word 4 = 0xDEADBEEF) -> gnt = 3'b010 in cycle T, port_rvalid = 3'b010 and port_rdata = 0xDEADBEEF in T+1, mem_we = 0 throughout.
- All three request continuously from reset, port2 writing -> grants rotate 001, 010, 100, 001...; mem_we = 1 exactly on port2 grant cycles.
- Write then read: port2 writes 0x12345678 to 0x020 in T; port0 reads 0x020 in T+1 -> port_rdata = 0x12345678 at T+2.
- Pointer hold: port0 alone requests for 3 cycles (granted each cycle), then ports 0 and 1 request together -> port1 granted first, since ptr = 1.
- UART path: port1 writes 0x0000_4101 to UART_BASE, then reads UART_BASE -> read data bits [15:8] = 0x41.
- Reset mid-operation: rst asserted the cycle after a port0 read grant -> port_rvalid stays 0, port_gnt = 0 during rst; after release the first grant goes to port0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice: default ram geometry,
// requester port indices and the IO/UART address map (also used by ram).
package mem_arbiter_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEF = 12;
  localparam int unsigned WIDTH_DEF         = 32;

  typedef enum logic [1:0] {
    PORT_IFETCH = 2'd0,
    PORT_LSU    = 2'd1,
    PORT_LOADER = 2'd2
  } port_id_e;

  localparam logic [11:0] IO_BASE     = 12'h800;
  localparam logic [11:0] UART_OFFSET = 12'h000;
  localparam logic [11:0] UART_BASE   = IO_BASE + UART_OFFSET;

  // Next index after i, wrapping modulo n.
  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotating-priority one-hot grant plus the pointer.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   req       per-requester request
//   gnt       one-hot grant (combinational), all-zero while rst or idle
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int unsigned   idx;
  logic          found;

  // Search from ptr upward, wrapping; the first asserted request wins and
  // the pointer moves just past the winner.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && !rst && req[idx[PW-1:0]]) begin
        found                = 1'b1;
        gnt[idx[PW-1:0]]     = 1'b1;
        ptr_d                = PW'(wrap_inc(idx, N));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single ram (combinational read, synchronous write, UART in IO
// space) between NUM_PORTS requesters: 0 = ifetch, 1 = load/store,
// 2 = boot loader. One transaction per clock, round-robin grant, read data
// registered one cycle after the grant.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   port_req/we/addr/wdata packed per-port requests (port i at slice i)
//   port_gnt              one-hot combinational grant
//   port_rvalid           one-hot registered read-valid pulse
//   port_rdata            shared read data, qualified by port_rvalid
//   mem_we/raddr/waddr/wdata  drive to ram; mem_rdata from ram
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned WIDTH         = WIDTH_DEF,
  parameter int unsigned NUM_PORTS     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             port_req,
  input  logic [NUM_PORTS-1:0]             port_we,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*WIDTH-1:0]       port_wdata,
  output logic [NUM_PORTS-1:0]             port_gnt,
  output logic [NUM_PORTS-1:0]             port_rvalid,
  output logic [WIDTH-1:0]                 port_rdata,
  output logic                             mem_we,
  output logic [ADDRESS_WIDTH-1:0]         mem_raddr,
  output logic [ADDRESS_WIDTH-1:0]         mem_waddr,
  output logic [WIDTH-1:0]                 mem_wdata,
  input  logic [WIDTH-1:0]                 mem_rdata
);

  logic [NUM_PORTS-1:0]     gnt;
  logic [NUM_PORTS-1:0]     rd_gnt;
  logic [ADDRESS_WIDTH-1:0] addr_sel;
  logic [WIDTH-1:0]         wdata_sel;
  logic [NUM_PORTS-1:0]     rvalid_q, rvalid_d;
  logic [WIDTH-1:0]         rdata_q, rdata_d;

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .clk (clk),
    .rst (rst),
    .req (port_req),
    .gnt (gnt)
  );

  // Grant is one-hot, so a plain select suffices; idle drives zeros.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        addr_sel  = port_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        wdata_sel = port_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rd_gnt    = gnt & ~port_we;
  assign port_gnt  = gnt;
  assign mem_we    = |(gnt & port_we);
  assign mem_raddr = addr_sel;
  assign mem_waddr = addr_sel;
  assign mem_wdata = wdata_sel;

  always_comb begin
    rvalid_d = rd_gnt;
    rdata_d  = rdata_q;
    if (|rd_gnt) rdata_d = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // A read granted just before rst asserts must not surface while rst is
  // high, so the registered pulse is masked by the live reset.
  assign port_rvalid = rvalid_q & {NUM_PORTS{~rst}};
  assign port_rdata  = rdata_q;

endmodule
